// File: rtl/mmio_mux_pipe.sv
// mmio_mux_pipe: pipelined MMIO multiplexor with base/mask windows, decode-miss reporting and a saturating error counter
package mmio_mux_pipe_pkg;
  localparam int MAX_W = 4096;
  function automatic logic [MAX_W-1:0] def_base(input int n, input int aw);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r | (MAX_W'(i) << (i * aw + 12));
    return r;
  endfunction
  function automatic logic [MAX_W-1:0] def_mask(input int n, input int aw);
    logic [MAX_W-1:0] r, m;
    r = '0;
    m = ({MAX_W{1'b1}} >> (MAX_W - aw)) & ~MAX_W'(12'hFFF);
    for (int i = 0; i < n; i++) r = r | (m << (i * aw));
    return r;
  endfunction
endpackage

module mmio_mux_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SLV_NUMBER = 16,
  parameter logic [SLV_NUMBER*ADDR_WIDTH-1:0] SLV_BASE =
    (SLV_NUMBER*ADDR_WIDTH)'(mmio_mux_pipe_pkg::def_base(SLV_NUMBER, ADDR_WIDTH)),
  parameter logic [SLV_NUMBER*ADDR_WIDTH-1:0] SLV_MASK =
    (SLV_NUMBER*ADDR_WIDTH)'(mmio_mux_pipe_pkg::def_mask(SLV_NUMBER, ADDR_WIDTH)),
  parameter int RD_LATENCY = 1,
  parameter int OUT_REG = 1,
  parameter logic [DATA_WIDTH-1:0] MISS_DATA = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/8-1:0]          wr_byteen,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_err,
  output logic                             wr_err,
  output logic [15:0]                      err_cnt,
  output logic [SLV_NUMBER-1:0]            slv_wr_en,
  output logic [SLV_NUMBER-1:0]            slv_rd_en,
  output logic [ADDR_WIDTH-1:0]            slv_wr_addr,
  output logic [DATA_WIDTH-1:0]            slv_wr_data,
  output logic [DATA_WIDTH/8-1:0]          slv_wr_byteen,
  output logic [ADDR_WIDTH-1:0]            slv_rd_addr,
  input  logic [SLV_NUMBER*DATA_WIDTH-1:0] slv_rd_data
);
  localparam int IW = SLV_NUMBER > 1 ? $clog2(SLV_NUMBER) : 1;

  logic          wr_hit, rd_hit;
  logic [IW-1:0] wr_idx, rd_idx;

  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    rd_hit = 1'b0;
    rd_idx = '0;
    for (int i = SLV_NUMBER - 1; i >= 0; i--) begin
      if ((wr_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        wr_hit = 1'b1;
        wr_idx = IW'(i);
      end
      if ((rd_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        rd_hit = 1'b1;
        rd_idx = IW'(i);
      end
    end
  end

  assign slv_wr_en     = (wr_en && wr_hit) ? SLV_NUMBER'(1) << wr_idx : '0;
  assign slv_rd_en     = (rd_en && rd_hit) ? SLV_NUMBER'(1) << rd_idx : '0;
  assign slv_wr_addr   = wr_addr;
  assign slv_wr_data   = wr_data;
  assign slv_wr_byteen = wr_byteen;
  assign slv_rd_addr   = rd_addr;

  logic [RD_LATENCY-1:0] v_q, h_q;
  logic [IW-1:0]         i_q [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= RD_LATENCY'({v_q, rd_en});
  end

  always_ff @(posedge clk) begin
    h_q    <= RD_LATENCY'({h_q, rd_hit});
    i_q[0] <= rd_idx;
    for (int k = 1; k < RD_LATENCY; k++) i_q[k] <= i_q[k-1];
  end

  logic                  last_v, last_h, last_e;
  logic [IW-1:0]         last_i;
  logic [DATA_WIDTH-1:0] last_d;

  assign last_v = v_q[RD_LATENCY-1] & ~rst;
  assign last_h = h_q[RD_LATENCY-1];
  assign last_i = i_q[RD_LATENCY-1];
  assign last_d = last_h ? slv_rd_data[last_i*DATA_WIDTH +: DATA_WIDTH] : MISS_DATA;
  assign last_e = last_v & ~last_h;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  rd_valid_q, rd_err_q;
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_q <= 1'b0;
          rd_err_q   <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= last_v;
          rd_err_q   <= last_e;
          if (last_v) rd_data_q <= last_d;
        end
      end
      assign rd_valid = rd_valid_q;
      assign rd_err   = rd_err_q;
      assign rd_data  = rd_data_q;
    end else begin : g_comb
      assign rd_valid = last_v;
      assign rd_err   = last_e;
      assign rd_data  = last_d;
    end
  endgenerate

  logic        wr_err_q;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] cnt_sum;

  always_comb begin
    cnt_sum   = {1'b0, err_cnt_q} + 17'(rd_err) + 17'(wr_err);
    err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_err_q  <= wr_en & ~wr_hit;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_err  = wr_err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_mmio_mux_pipe.sv
// tb_mmio_mux_pipe: scoreboard bench for the default mux plus directed checks on a deep-latency, overlapping-window variant
module tb_mmio_mux_pipe;
  localparam int AW = 32, DW = 64, NS = 16, BDW = 32, BNS = 4;

  logic clk = 1'b0, rst = 1'b1, b_rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           a_wr_en = 0, a_rd_en = 0;
  logic [AW-1:0]  a_wr_addr = 0, a_rd_addr = 0;
  logic [DW-1:0]  a_wr_data = 0;
  logic [7:0]     a_wr_byteen = 0;
  logic           a_rd_valid, a_rd_err, a_wr_err;
  logic [DW-1:0]  a_rd_data;
  logic [15:0]    a_err_cnt;
  logic [NS-1:0]  a_slv_wr_en, a_slv_rd_en;
  logic [AW-1:0]  a_slv_wr_addr, a_slv_rd_addr;
  logic [DW-1:0]  a_slv_wr_data;
  logic [7:0]     a_slv_wr_byteen;
  logic [NS*DW-1:0] a_slv_rd_data;

  mmio_mux_pipe u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_byteen(a_wr_byteen), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_valid(a_rd_valid),
    .rd_data(a_rd_data), .rd_err(a_rd_err), .wr_err(a_wr_err), .err_cnt(a_err_cnt),
    .slv_wr_en(a_slv_wr_en), .slv_rd_en(a_slv_rd_en), .slv_wr_addr(a_slv_wr_addr),
    .slv_wr_data(a_slv_wr_data), .slv_wr_byteen(a_slv_wr_byteen), .slv_rd_addr(a_slv_rd_addr),
    .slv_rd_data(a_slv_rd_data)
  );

  logic            b_wr_en = 0, b_rd_en = 0;
  logic [AW-1:0]   b_wr_addr = 0, b_rd_addr = 0;
  logic [BDW-1:0]  b_wr_data = 0;
  logic [3:0]      b_wr_byteen = 0;
  logic            b_rd_valid, b_rd_err, b_wr_err;
  logic [BDW-1:0]  b_rd_data;
  logic [15:0]     b_err_cnt;
  logic [BNS-1:0]  b_slv_wr_en, b_slv_rd_en;
  logic [AW-1:0]   b_slv_wr_addr, b_slv_rd_addr;
  logic [BDW-1:0]  b_slv_wr_data;
  logic [3:0]      b_slv_wr_byteen;
  logic [BNS*BDW-1:0] b_slv_rd_data;

  mmio_mux_pipe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(BDW), .SLV_NUMBER(BNS),
    .SLV_BASE({32'h20000, 32'h10000, 32'h05000, 32'h00000}),
    .SLV_MASK({32'hFFFF0000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000}),
    .RD_LATENCY(3), .OUT_REG(0), .MISS_DATA(32'hDEADBEEF)
  ) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_byteen(b_wr_byteen), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .rd_err(b_rd_err), .wr_err(b_wr_err), .err_cnt(b_err_cnt),
    .slv_wr_en(b_slv_wr_en), .slv_rd_en(b_slv_rd_en), .slv_wr_addr(b_slv_wr_addr),
    .slv_wr_data(b_slv_wr_data), .slv_wr_byteen(b_slv_wr_byteen), .slv_rd_addr(b_slv_rd_addr),
    .slv_rd_data(b_slv_rd_data)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Slave contents: a recognisable tag of slave index and address
  function automatic logic [63:0] sdata(input int i, input logic [31:0] a);
    return {a ^ (32'(i) * 32'h9E3779B9), 8'(i), a[23:0]};
  endfunction

  always @(posedge clk)
    for (int i = 0; i < NS; i++)
      a_slv_rd_data[i*DW +: DW] <= a_slv_rd_en[i] ? sdata(i, a_slv_rd_addr) : {$urandom, $urandom};

  logic [BDW-1:0] b_p1 [BNS], b_p2 [BNS];
  always @(posedge clk)
    for (int i = 0; i < BNS; i++) begin
      b_p1[i] <= b_slv_rd_en[i] ? 32'(sdata(i, b_slv_rd_addr)) : $urandom;
      b_p2[i] <= b_p1[i];
      b_slv_rd_data[i*BDW +: BDW] <= b_p2[i];
    end

  typedef struct {int c; logic err; logic [63:0] data;} rd_exp_t;
  rd_exp_t rd_q[$];
  int      adds[int];
  bit      wmiss[int];
  int      reset_at = -1, exp_cnt = 0;
  bit      mon_en = 1'b0;

  // Default map: slave n owns [n*0x1000, n*0x1000+0xFFF] for n < 16
  function automatic int dec_a(input logic [31:0] a);
    return a < 32'h10000 ? int'(a >> 12) : -1;
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 4) == 0) return 32'h10000 + ($urandom & 32'h00FF_FFFF);
    return (32'($urandom_range(0, 15)) << 12) | ($urandom & 32'hFFF);
  endfunction

  function automatic void add_at(input int c);
    adds[c] = adds.exists(c) ? adds[c] + 1 : 1;
  endfunction

  task automatic step_a(input bit r_en, input logic [31:0] r_a, input bit w_en,
                        input logic [31:0] w_a, input bit do_rst);
    int rs, ws;
    logic [63:0] wd;
    logic [7:0] be;
    @(posedge clk); #1;
    wd = {$urandom, $urandom};
    be = 8'($urandom);
    rst = do_rst; a_rd_en = r_en; a_rd_addr = r_a; a_wr_en = w_en;
    a_wr_addr = w_a; a_wr_data = wd; a_wr_byteen = be;
    rs = dec_a(r_a);
    ws = dec_a(w_a);
    if (r_en) begin
      rd_q.push_back('{cyc + 2, rs < 0, rs < 0 ? 64'h0 : sdata(rs, r_a)});
      if (rs < 0) add_at(cyc + 2);
    end
    if (w_en && ws < 0) begin
      wmiss[cyc + 1] = 1'b1;
      add_at(cyc + 1);
    end
    if (do_rst) begin
      while (rd_q.size() > 0 && rd_q[$].c > cyc) void'(rd_q.pop_back());
      for (int d = 1; d <= 2; d++) begin
        adds.delete(cyc + d);
        wmiss.delete(cyc + d);
      end
      reset_at = cyc + 1;
    end
    #1;
    chk("slv_rd_en", 64'(a_slv_rd_en), (r_en && rs >= 0) ? 64'(1) << rs : 64'h0);
    chk("slv_wr_en", 64'(a_slv_wr_en), (w_en && ws >= 0) ? 64'(1) << ws : 64'h0);
    chk("slv_wr_addr", 64'(a_slv_wr_addr), 64'(w_a));
    chk("slv_wr_data", a_slv_wr_data, wd);
    chk("slv_wr_byteen", 64'(a_slv_wr_byteen), 64'(be));
    chk("slv_rd_addr", 64'(a_slv_rd_addr), 64'(r_a));
  endtask

  always @(negedge clk) begin : mon
    rd_exp_t e;
    if (mon_en) begin
      if (cyc == reset_at) begin
        exp_cnt = 0;
        chk("reset_rd_data", a_rd_data, 64'h0);
        chk("reset_rd_valid", 64'(a_rd_valid), 64'h0);
      end
      if (!a_rd_valid) chk("rd_err_idle", 64'(a_rd_err), 64'h0);
      while (rd_q.size() > 0 && rd_q[0].c < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_missing: got no rd_valid by cycle %0d, expected one at cycle %0d", cyc, rd_q[0].c);
        void'(rd_q.pop_front());
      end
      if (a_rd_valid) begin
        if (rd_q.size() > 0 && rd_q[0].c == cyc) begin
          e = rd_q.pop_front();
          chk("rd_data", a_rd_data, e.data);
          chk("rd_err", 64'(a_rd_err), 64'(e.err));
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_extra: got rd_valid=1 at cycle %0d, expected 0", cyc);
        end
      end
      chk("wr_err", 64'(a_wr_err), 64'(wmiss.exists(cyc)));
      wmiss.delete(cyc);
      chk("err_cnt", 64'(a_err_cnt), 64'(exp_cnt));
      if (adds.exists(cyc)) begin
        exp_cnt = exp_cnt + adds[cyc] > 32'hFFFF ? 32'hFFFF : exp_cnt + adds[cyc];
        adds.delete(cyc);
      end
    end
  end

  task automatic bstep(input bit r, input logic [31:0] ra, input bit w,
                       input logic [31:0] wa, input logic [3:0] be, input bit rs_);
    @(posedge clk); #1;
    b_rst = rs_; b_rd_en = r; b_rd_addr = ra; b_wr_en = w; b_wr_addr = wa;
    b_wr_byteen = be; b_wr_data = $urandom;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test by cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    step_a(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    step_a(1, 32'h2008, 0, 0, 0);
    step_a(1, 32'h1000, 0, 0, 0);
    step_a(1, 32'h3000, 0, 0, 0);
    step_a(1, 32'h1000, 0, 0, 0);
    step_a(1, 32'h20000, 1, 32'h20000, 0);
    step_a(0, 0, 1, 32'h0F008, 0);
    repeat (3) step_a(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step_a($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 1) == 1, rnd_addr(), i == 200);
    step_a(0, 0, 0, 0, 1);
    step_a(1, 32'h20000 | ($urandom & 32'hFFFF), 0, 0, 0);
    repeat (32780) step_a(1, 32'h30000 | ($urandom & 32'hFFFF), 1, 32'h40000, 0);
    repeat (4) step_a(0, 0, 0, 0, 0);
    chk("err_cnt_saturated", 64'(a_err_cnt), 64'hFFFF);

    bstep(0, 0, 0, 0, 0, 1);
    bstep(0, 0, 0, 0, 0, 0);
    bstep(1, 32'h10010, 0, 0, 0, 0);
    chk("b_slv_rd_en_s2", 64'(b_slv_rd_en), 64'h4);
    bstep(0, 0, 0, 0, 0, 1);
    bstep(1, 32'h00040, 0, 0, 0, 0);
    chk("b_slv_rd_en_s0", 64'(b_slv_rd_en), 64'h1);
    bstep(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_flushed_valid", 64'(b_rd_valid), 64'h0);
    chk("b_reset_err_cnt", 64'(b_err_cnt), 64'h0);
    bstep(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_early_valid", 64'(b_rd_valid), 64'h0);
    bstep(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_rd_valid", 64'(b_rd_valid), 64'h1);
    chk("b_rd_data", 64'(b_rd_data), 64'(32'(sdata(0, 32'h40))));
    chk("b_rd_err", 64'(b_rd_err), 64'h0);
    bstep(0, 0, 1, 32'h5000, 4'h0F, 0);
    chk("b_overlap_wr_en", 64'(b_slv_wr_en), 64'h1);
    chk("b_wr_byteen_pass", 64'(b_slv_wr_byteen), 64'h0F);
    chk("b_wr_data_pass", 64'(b_slv_wr_data), 64'(b_wr_data));
    bstep(0, 0, 1, 32'h10ABC, 4'h3, 0);
    chk("b_s2_wr_en", 64'(b_slv_wr_en), 64'h4);
    @(negedge clk);
    chk("b_wr_err_hit", 64'(b_wr_err), 64'h0);
    bstep(0, 0, 1, 32'h40000, 4'hF, 0);
    chk("b_miss_wr_en", 64'(b_slv_wr_en), 64'h0);
    bstep(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_wr_err_pulse", 64'(b_wr_err), 64'h1);
    bstep(1, 32'h30000, 0, 0, 0, 0);
    chk("b_miss_rd_en", 64'(b_slv_rd_en), 64'h0);
    @(negedge clk);
    chk("b_wr_err_one_cycle", 64'(b_wr_err), 64'h0);
    chk("b_err_cnt_wr", 64'(b_err_cnt), 64'h1);
    for (int k = 1; k <= 2; k++) begin
      bstep(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("b_miss_not_yet", 64'({b_rd_valid, b_rd_err}), 64'h0);
    end
    bstep(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_miss_valid", 64'({b_rd_valid, b_rd_err}), 64'h3);
    chk("b_miss_data", 64'(b_rd_data), 64'hDEADBEEF);
    bstep(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_err_cnt_rd", 64'(b_err_cnt), 64'h2);
    chk("b_valid_pulse", 64'(b_rd_valid), 64'h0);

    repeat (4) step_a(0, 0, 0, 0, 0);
    chk("scoreboard_drained", 64'(rd_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_mux_pipe.md
Name: mmio_mux_pipe

Overview:
Parametrised MMIO multiplexor. It connects one MMIO master to SLV_NUMBER MMIO slaves through per-slave base/mask address windows. Slave read latency is fixed at RD_LATENCY and reads are fully pipelined, so back-to-back reads may target different slaves. An optional output register, a read-valid strobe, decode-miss error reporting and a saturating error counter are included. It sits between a bus bridge and the peripheral register blocks, as the next generation of the plain combinational multiplexor.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 64, data width; must be a multiple of 8.
SLV_NUMBER, 16, number of slaves; must be at least 1.
SLV_BASE, slave i at i*0x1000, packed SLV_NUMBER*ADDR_WIDTH base addresses; slave i occupies slice i.
SLV_MASK, ~0xFFF for all slaves, packed SLV_NUMBER*ADDR_WIDTH decode masks.
RD_LATENCY, 1, cycles from slv_rd_en to valid slv_rd_data; must be at least 1.
OUT_REG, 1, 1 adds an output register stage on rd_data/rd_valid/rd_err; 0 drives them combinationally from the last pipeline stage.
MISS_DATA, 0, value returned in rd_data on a read decode miss.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  master write strobe
wr_addr  in  ADDR_WIDTH  master write address
wr_data  in  DATA_WIDTH  master write data
wr_byteen  in  DATA_WIDTH/8  master write byte enables
rd_en  in  1  master read strobe
rd_addr  in  ADDR_WIDTH  master read address
rd_valid  out  1  read data valid, one-cycle pulse per read
rd_data  out  DATA_WIDTH  read data
rd_err  out  1  qualifies rd_valid; 1 means decode miss
wr_err  out  1  registered pulse; the write one cycle earlier missed all windows
err_cnt  out  16  saturating count of read and write misses
slv_wr_en  out  SLV_NUMBER  one-hot write strobe
slv_rd_en  out  SLV_NUMBER  one-hot read strobe
slv_wr_addr / slv_wr_data / slv_wr_byteen  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  wr_addr, wr_data and wr_byteen passed straight through
slv_rd_addr  out  ADDR_WIDTH  rd_addr passed straight through
slv_rd_data  in  SLV_NUMBER*DATA_WIDTH  packed slave read data; slave i occupies slice i

Behaviour:
- Decode: slave i hits when (addr & SLV_MASK[i]) == SLV_BASE[i]. If several windows hit, the lowest index wins, so strobes stay one-hot. Decode is combinational: slv_wr_en/slv_rd_en assert in the same cycle as wr_en/rd_en, with zero added latency on the request path.
- Miss: no slave strobe asserts.
- Read pipeline: RD_LATENCY stages, each holding {valid, hit, index}. Stage 0 loads {rd_en, hit, index} each cycle.
  - At the last stage, data = hit ? slv_rd_data[index] : MISS_DATA; err = valid & ~hit.
  - rd_valid asserts exactly RD_LATENCY+OUT_REG cycles after the rd_en cycle.
  - A new read is accepted every cycle; there is no stall and no backpressure.
- Output values when rd_valid=0:
  - OUT_REG=1: rd_data holds its last value.
  - OUT_REG=0: rd_data is don't-care.
  - rd_err is 0 whenever rd_valid is 0.
- Writes are posted. wr_err pulses high for one cycle, in the cycle after a wr_en that missed.
- Read and write channels are independent. wr_en and rd_en in the same cycle are both serviced, even to the same slave.
- err_cnt increments by 1 for each read miss, counted when its rd_valid/rd_err is presented, and by 1 for each write miss, counted when wr_err is presented. A read miss and a write miss presented in the same cycle add 2. The counter saturates at 0xFFFF and never wraps.
- Reset, synchronous and active-high:
  - rd_valid, rd_err, wr_err = 0; rd_data = 0; err_cnt = 0.
  - All pipeline valid bits are cleared. Reads in flight when rst asserts never produce rd_valid.
  - slv_* strobes follow the inputs combinationally and are not gated by rst.
- The address/data pass-throughs are unregistered.

Test Plan:
1. Defaults. Read 0x2008 at cycle T; slave 2 returns 0xA5A5 at T+1 -> slv_rd_en=0x0004 at T; rd_valid=1, rd_data=0xA5A5, rd_err=0 at T+2 only.
2. Back-to-back reads of 0x1000, 0x3000, 0x1000 on consecutive cycles; slaves return 0x11, 0x33, 0x11 -> rd_valid high for 3 consecutive cycles with data 0x11, 0x33, 0x11 in order.
3. Read 0x20000 (outside all windows) -> no slv_rd_en; 2 cycles later rd_valid=1, rd_err=1, rd_data=MISS_DATA=0; err_cnt=1. Write 0x20000 -> wr_err pulse next cycle; err_cnt=2.
4. Overlapping windows: SLV_BASE[0]=0, SLV_MASK[0]=0 (matches all), slave 5 at 0x5000 -> write 0x5000 with byteen 0x0F asserts only slv_wr_en[0]; wr_data/byteen passed unchanged.
5. RD_LATENCY=3, OUT_REG=0. Read at T, then rst high at T+1 for one cycle -> no rd_valid at T+3; a read issued at T+2 returns rd_valid at T+5.
6. Force err_cnt to 0xFFFE, then a read miss and a write miss present in the same cycle -> err_cnt=0xFFFF and stays there on further misses.
